// File: rtl/escalonador_processos_if.sv
// Scheduler bus: switch/creation/termination requests in, next-PC load and status out.
interface escalonador_processos_if #(
  parameter int ID_W = 3,
  parameter int PC_W = 32
);
  logic            troca_contexto;
  logic [PC_W-1:0] pc_processo_trocado;
  logic            fim_processo;
  logic            cria_processo;
  logic [ID_W-1:0] id_novo;
  logic [PC_W-1:0] pc_inicial;
  logic [ID_W-1:0] processo_atual;
  logic [PC_W-1:0] pc_proximo;
  logic            carrega_pc;
  logic            ocupado;
  logic            nenhum_processo;

  modport master (
    output troca_contexto, pc_processo_trocado, fim_processo,
    output cria_processo, id_novo, pc_inicial,
    input  processo_atual, pc_proximo, carrega_pc, ocupado, nenhum_processo
  );

  modport slave (
    input  troca_contexto, pc_processo_trocado, fim_processo,
    input  cria_processo, id_novo, pc_inicial,
    output processo_atual, pc_proximo, carrega_pc, ocupado, nenhum_processo
  );
endinterface

// File: rtl/escalonador_processos.sv
// Round-robin process scheduler: saves the interrupted PC, scans one slot per cycle
// for the next ready process and pulses carrega_pc with its PC (SO_PC if none ready).
module escalonador_processos #(
  parameter int              NUM_PROC = 8,
  parameter int              ID_W     = 3,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] SO_PC    = '0
) (
  input logic                    clock,
  input logic                    reset,
  escalonador_processos_if.slave bus
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] SALVA   = 2'd1;
  localparam logic [1:0] BUSCA   = 2'd2;
  localparam logic [1:0] CARREGA = 2'd3;

  localparam logic [ID_W:0] ULTIMO = (ID_W+1)'(NUM_PROC - 1);

  logic [1:0]          estado_q, estado_d;
  logic [ID_W-1:0]     atual_q, atual_d;
  logic [ID_W-1:0]     idx_q, idx_d;
  logic [ID_W:0]       cont_q, cont_d;
  logic [PC_W-1:0]     pc_prox_q, pc_prox_d;
  logic [PC_W-1:0]     hold_q, hold_d;
  logic                nenhum_q, nenhum_d;
  logic                troca_ant_q;
  logic                fim_pend_q, fim_pend_d;
  logic [PC_W-1:0]     tabela_q [NUM_PROC];
  logic [PC_W-1:0]     tabela_d [NUM_PROC];
  logic [NUM_PROC-1:0] pronto_q, pronto_d;

  logic pedido_troca;
  logic fim_ativo;

  assign pedido_troca = bus.troca_contexto & ~troca_ant_q;
  assign fim_ativo    = bus.fim_processo | fim_pend_q;

  always_comb begin
    estado_d   = estado_q;
    atual_d    = atual_q;
    idx_d      = idx_q;
    cont_d     = cont_q;
    pc_prox_d  = pc_prox_q;
    hold_d     = hold_q;
    nenhum_d   = nenhum_q;
    fim_pend_d = fim_pend_q;
    tabela_d   = tabela_q;
    pronto_d   = pronto_q;

    case (estado_q)
      OCIOSO: begin
        if (fim_ativo) begin
          pronto_d[atual_q] = 1'b0;
          fim_pend_d        = 1'b0;
          idx_d             = atual_q + 1'b1;
          cont_d            = '0;
          estado_d          = BUSCA;
        end else if (pedido_troca) begin
          hold_d   = bus.pc_processo_trocado;
          estado_d = SALVA;
        end
      end
      SALVA: begin
        tabela_d[atual_q] = hold_q;
        idx_d             = atual_q + 1'b1;
        cont_d            = '0;
        estado_d          = BUSCA;
      end
      BUSCA: begin
        // The running slot is the last one examined, so it is only re-picked when alone.
        if (pronto_q[idx_q]) begin
          atual_d   = idx_q;
          pc_prox_d = tabela_q[idx_q];
          nenhum_d  = 1'b0;
          estado_d  = CARREGA;
        end else if (cont_q == ULTIMO) begin
          pc_prox_d = SO_PC;
          nenhum_d  = 1'b1;
          estado_d  = CARREGA;
        end else begin
          idx_d  = idx_q + 1'b1;
          cont_d = cont_q + 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // A termination that arrives mid-selection is remembered and served once idle.
    if (estado_q != OCIOSO && bus.fim_processo) begin
      fim_pend_d = 1'b1;
    end

    if (bus.cria_processo) begin
      tabela_d[bus.id_novo] = bus.pc_inicial;
      pronto_d[bus.id_novo] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      atual_q     <= '0;
      idx_q       <= '0;
      cont_q      <= '0;
      pc_prox_q   <= '0;
      hold_q      <= '0;
      nenhum_q    <= 1'b1;
      troca_ant_q <= 1'b0;
      fim_pend_q  <= 1'b0;
      pronto_q    <= '0;
      for (int i = 0; i < NUM_PROC; i++) begin
        tabela_q[i] <= '0;
      end
    end else begin
      estado_q    <= estado_d;
      atual_q     <= atual_d;
      idx_q       <= idx_d;
      cont_q      <= cont_d;
      pc_prox_q   <= pc_prox_d;
      hold_q      <= hold_d;
      nenhum_q    <= nenhum_d;
      troca_ant_q <= bus.troca_contexto;
      fim_pend_q  <= fim_pend_d;
      pronto_q    <= pronto_d;
      tabela_q    <= tabela_d;
    end
  end

  assign bus.processo_atual  = atual_q;
  assign bus.pc_proximo      = pc_prox_q;
  assign bus.carrega_pc      = (estado_q == CARREGA);
  assign bus.ocupado         = (estado_q != OCIOSO);
  assign bus.nenhum_processo = nenhum_q;

endmodule

// File: tb/tb_escalonador_processos.sv
// Directed bench for escalonador_processos; expected load pulses are queued by the driver
// and matched by a monitor on every carrega_pc pulse.
module tb_escalonador_processos;

  localparam logic [31:0] SO = 32'd999;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  id;
    logic        nenhum;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];

  escalonador_processos_if #(.ID_W(3), .PC_W(32)) bus ();

  escalonador_processos #(
    .NUM_PROC(8), .ID_W(3), .PC_W(32), .SO_PC(SO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, act, exp, cyc);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && bus.carrega_pc === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL carrega_extra: unexpected pulse at cycle %0d, pc %0d", cyc, bus.pc_proximo);
      end else begin
        e = sb.pop_front();
        chk("pc_proximo", bus.pc_proximo, e.pc);
        chk("processo_atual", 32'(bus.processo_atual), 32'(e.id));
        chk("nenhum_processo", 32'(bus.nenhum_processo), 32'(e.nenhum));
        chk("latencia", cyc, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // m = cycle, counted from the sampling edge, in which carrega_pc is expected high
  task automatic espera(input logic [31:0] pc, input logic [2:0] id, input logic nen, input int m);
    sb.push_back('{pc, id, nen, cyc + m});
  endtask

  task automatic cria(input logic [2:0] id, input logic [31:0] pc);
    bus.cria_processo = 1'b1;
    bus.id_novo       = id;
    bus.pc_inicial    = pc;
    step(1);
    bus.cria_processo = 1'b0;
  endtask

  task automatic troca(input logic [31:0] pc);
    bus.troca_contexto      = 1'b1;
    bus.pc_processo_trocado = pc;
    step(1);
    bus.troca_contexto = 1'b0;
  endtask

  task automatic fim();
    bus.fim_processo = 1'b1;
    step(1);
    bus.fim_processo = 1'b0;
  endtask

  task automatic drena(input int orcamento);
    int n = 0;
    while (sb.size() != 0 && n < orcamento) begin
      step(1);
      n++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL timeout: %0d expected pulses missing after %0d cycles", sb.size(), orcamento);
      sb.delete();
    end
    step(2);
  endtask

  task automatic chk_repouso(input string tag);
    chk({tag, "_ocupado"}, 32'(bus.ocupado), 32'd0);
    chk({tag, "_carrega_pc"}, 32'(bus.carrega_pc), 32'd0);
    chk({tag, "_nenhum"}, 32'(bus.nenhum_processo), 32'd1);
    chk({tag, "_processo_atual"}, 32'(bus.processo_atual), 32'd0);
    chk({tag, "_pc_proximo"}, bus.pc_proximo, 32'd0);
  endtask

  initial begin
    bus.troca_contexto      = 1'b0;
    bus.pc_processo_trocado = '0;
    bus.fim_processo        = 1'b0;
    bus.cria_processo       = 1'b0;
    bus.id_novo             = '0;
    bus.pc_inicial          = '0;
    step(2);
    reset = 1'b0;
    chk_repouso("reset");

    // 1: basic switch 0 -> 1, table[0] <- 305
    cria(3'd0, 32'd301);
    cria(3'd1, 32'd400);
    cria(3'd2, 32'd500);
    espera(32'd400, 3'd1, 1'b0, 3);
    troca(32'd305);
    drena(20);

    // 2: level held 6 cycles gives one pulse; table[1] <- 510
    espera(32'd500, 3'd2, 1'b0, 3);
    bus.troca_contexto      = 1'b1;
    bus.pc_processo_trocado = 32'd510;
    step(6);
    bus.troca_contexto = 1'b0;
    drena(20);

    // 3: wrap from 2 over empty 3..7 to slot 0 (saved 305)
    espera(32'd305, 3'd0, 1'b0, 8);
    troca(32'd520);
    drena(20);

    // 4: retire processes down to a lone running slot 1, then no-hit scan
    espera(32'd510, 3'd1, 1'b0, 2);
    fim();
    drena(20);
    espera(32'd520, 3'd2, 1'b0, 3);
    troca(32'd600);
    drena(20);
    espera(32'd600, 3'd1, 1'b0, 8);
    fim();
    drena(20);
    espera(SO, 3'd1, 1'b1, 9);
    fim();
    drena(20);

    // 5: fim during BUSCA is deferred, a troca edge during BUSCA is dropped
    cria(3'd4, 32'd700);
    cria(3'd6, 32'd800);
    espera(32'd700, 3'd4, 1'b0, 5);
    espera(32'd800, 3'd6, 1'b0, 9);
    troca(32'd610);
    step(1);
    troca(32'd611);
    fim();
    drena(30);

    // 6: reset in the middle of a scan aborts it and clears the ready table
    troca(32'd900);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_repouso("reset_busca");
    espera(SO, 3'd0, 1'b1, 10);
    troca(32'd1234);
    drena(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/escalonador_processos.md
Name: escalonador_processos

Overview:
Round-robin process scheduler sitting directly downstream of the quantum counter.
- Consumes the counter's context-switch request and the saved PC of the interrupted process.
- Stores that PC in a per-process table and selects the next ready process.
- Hands the next PC to the PC-update logic with a one-cycle load pulse.
- Also handles process creation (from the OS) and process termination.

Parameters:
NUM_PROC, 8, number of process slots in the table (power of two)
ID_W, 3, width of a process id (log2 NUM_PROC)
PC_W, 32, width of a program counter
SO_PC, 32'd0, PC driven when no process is ready (OS entry point)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
troca_contexto  input  1  switch request from quantum counter (level; block acts on its 0->1 transition)
pc_processo_trocado  input  PC_W  resume PC of the interrupted process, valid while troca_contexto is high
fim_processo  input  1  one-cycle pulse: the current process has finished
cria_processo  input  1  one-cycle pulse: load slot id_novo
id_novo  input  ID_W  slot written by cria_processo
pc_inicial  input  PC_W  start PC for the created process
processo_atual  output  ID_W  id of the running process
pc_proximo  output  PC_W  PC to load, valid while carrega_pc=1
carrega_pc  output  1  one-cycle pulse: PC logic must load pc_proximo
ocupado  output  1  high whenever the FSM is not in OCIOSO
nenhum_processo  output  1  high when the last selection found no ready slot

Behaviour:
- Reset (sampled at a rising edge with reset=1):
  - state=OCIOSO; processo_atual=0; pc_proximo=0; carrega_pc=0; ocupado=0; nenhum_processo=1.
  - All table PCs=0; all ready bits=0; troca edge register=0; fim_pendente=0.
  - reset mid-operation aborts any scan immediately.
- Edge detect:
  - troca_ant registers troca_contexto every cycle.
  - Request = troca_contexto & ~troca_ant.
  - A level held high across cycles produces exactly one request.
- State OCIOSO, priority fim_processo (or fim_pendente) > troca request:
  - fim: clear ready[processo_atual], clear fim_pendente, idx=processo_atual+1 (mod NUM_PROC), go BUSCA.
  - troca request: go SALVA, capturing pc_processo_trocado into a holding register.
- State SALVA (1 cycle): table[processo_atual]=holding PC; idx=processo_atual+1 mod NUM_PROC; go BUSCA.
- State BUSCA (one slot per cycle):
  - Examine ready[idx], using registered table state.
  - If ready: latch sel=idx and go CARREGA.
  - Else: idx=idx+1 mod NUM_PROC (wraps NUM_PROC-1 -> 0); scan counter +1.
  - After NUM_PROC examined slots with no hit (the current slot is examined last): go CARREGA with no-hit flag.
- State CARREGA (1 cycle):
  - carrega_pc=1, then return to OCIOSO.
  - Hit: processo_atual=sel, pc_proximo=table[sel], nenhum_processo=0.
  - No hit: processo_atual unchanged, pc_proximo=SO_PC, nenhum_processo=1.
- Latency: troca edge sampled at edge E0 -> SALVA in cycle 1, BUSCA from cycle 2 -> carrega_pc high in cycle 2+k, where k = number of slots examined (k=1 when the next slot is ready). The fim path is one cycle shorter (no SALVA).
- While ocupado=1:
  - troca requests are dropped (the quantum counter zeroes itself, so no loss of correctness).
  - fim_processo sets fim_pendente, served on the first OCIOSO cycle.
- cria_processo is accepted in any state: table[id_novo]=pc_inicial, ready[id_novo]=1 at that edge. A scan examining that slot in the same cycle sees the old ready value.
- cria_processo targeting the running slot overwrites its PC and sets ready; it is the OS's responsibility not to do this.
- Width rules: idx and processo_atual are ID_W bits wrapping naturally; the scan counter is ID_W+1 bits; PCs are stored unmodified (no +1 applied here).

Test Plan:
1. reset, then cria slots 0 (pc 301), 1 (pc 400), 2 (pc 500), current=0; pulse troca with pc_processo_trocado=305 -> table[0]=305, carrega_pc exactly 3 cycles after the sampled edge, pc_proximo=400, processo_atual=1.
2. Hold troca_contexto high 6 cycles -> exactly one carrega_pc pulse.
3. Current=2 with slots 3..7 empty, slot 0 ready -> scan wraps to 0, pc_proximo=table[0]; carrega_pc 2+6 cycles after the edge.
4. Only slot 1 ready and running; fim_processo -> NUM_PROC slots scanned, pc_proximo=SO_PC, nenhum_processo=1, processo_atual stays 1.
5. fim_processo during BUSCA of a troca -> a second selection starts the cycle after returning to OCIOSO; troca during BUSCA is ignored.
6. Assert reset in the middle of a BUSCA -> next cycle: ocupado=0, carrega_pc=0, all ready=0, nenhum_processo=1.
